// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map,
// cause-register bit positions and the interrupt-line count.
package irq_pkg;

    localparam int NUM_IRQ = 4;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_EPC     = 2'd2;
    localparam logic [1:0] ADDR_CAUSE   = 2'd3;

    localparam int CAUSE_DF_BIT  = 7;
    localparam int CAUSE_EXC_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAP   = 2'd1,
        ST_KERNEL = 2'd2
    } state_e;

    // One-hot of the lowest set bit; lowest index has the highest priority.
    function automatic logic [NUM_IRQ-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [NUM_IRQ-1:0] r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for asynchronous level inputs, followed by a
// rising-edge detector on the synchronized value.
module irq_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: non-blocking assignments let every stage sample the old value of
    // the previous stage; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: pends synchronized source edges, arbitrates against
// the mask, and sequences IDLE -> TRAP -> KERNEL around each trap.
module irq_ctl
    import irq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq_src,
    input  logic [31:0] pc,
    input  logic        pc31,
    input  logic        exception,
    output logic        irq,
    output logic [31:0] epc,
    output logic [7:0]  cause,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata
);

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [31:0]          epc_q, epc_d;
    logic [7:0]           cause_q, cause_d;

    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   enabled;
    logic [NUM_IRQ-1:0]   pending_clr;
    logic                 unused_wdata;

    assign unused_wdata = ^{cfg_wdata[31:8], cfg_wdata[6:4]};

    irq_sync #(.WIDTH(NUM_IRQ)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (irq_src),
        .rise     (rise)
    );

    assign enabled     = pending_q & mask_q;
    assign pending_clr = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[NUM_IRQ-1:0] : '0;

    // NOTE: every variable gets its hold value first so no path through the
    // case/if tree leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        // A new edge wins over a software clear on the same bit.
        pending_d = (pending_q & ~pending_clr) | rise;

        if (cfg_we && cfg_addr == ADDR_MASK) begin
            mask_d = cfg_wdata[NUM_IRQ-1:0];
        end
        if (cfg_we && cfg_addr == ADDR_CAUSE && cfg_wdata[CAUSE_DF_BIT]) begin
            cause_d[CAUSE_DF_BIT] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!pc31 && (exception || (|enabled))) begin
                    state_d                = ST_TRAP;
                    epc_d                  = pc;
                    cause_d[CAUSE_EXC_BIT] = exception;
                    cause_d[NUM_IRQ-1:0]   = exception ? '0 : lowest_set(enabled);
                end
            end
            ST_TRAP: begin
                state_d = ST_KERNEL;
                if (exception) cause_d[CAUSE_DF_BIT] = 1'b1;
            end
            ST_KERNEL: begin
                if (exception) cause_d[CAUSE_DF_BIT] = 1'b1;
                if (!pc31)     state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register here is a plain flop and is cleared by reset;
    // there is no memory array whose contents would be left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            pending_q <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
        end
    end

    // Exception traps are taken by the decoder itself, so only interrupts pulse irq.
    assign irq   = (state_q == ST_TRAP) && !cause_q[CAUSE_EXC_BIT];
    assign epc   = epc_q;
    assign cause = cause_q;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MASK:    cfg_rdata[NUM_IRQ-1:0] = mask_q;
            ADDR_PENDING: cfg_rdata[NUM_IRQ-1:0] = pending_q;
            ADDR_EPC:     cfg_rdata              = epc_q;
            default:      cfg_rdata[7:0]         = cause_q;
        endcase
    end

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: a reference model checked every cycle, plus
// hand-computed expectations for each scenario.
module tb_irq_ctl;
    import irq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic [31:0] pc;
    logic        pc31;
    logic        exception;
    logic        irq;
    logic [31:0] epc;
    logic [7:0]  cause;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    irq_ctl dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .pc        (pc),
        .pc31      (pc31),
        .exception (exception),
        .irq       (irq),
        .epc       (epc),
        .cause     (cause),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: handler modes, source history, register contents.
    localparam int M_IDLE   = 0;
    localparam int M_TRAP   = 1;
    localparam int M_KERNEL = 2;

    int          m_mode;
    logic [3:0]  m_mask, m_pending;
    logic [31:0] m_epc;
    logic [7:0]  m_cause;
    logic        m_irq;
    logic [3:0]  src_hist [3];   // [0] = last edge's sample, [2] = three edges ago

    function automatic logic [3:0] winner(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
        return 4'h0;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        case (a)
            ADDR_MASK:    return {28'h0, m_mask};
            ADDR_PENDING: return {28'h0, m_pending};
            ADDR_EPC:     return m_epc;
            default:      return {24'h0, m_cause};
        endcase
    endfunction

    always @(posedge clk) begin : ref_model
        logic [3:0] rise, enabled, clr;
        if (reset) begin
            m_mode = M_IDLE; m_mask = 0; m_pending = 0; m_epc = 0; m_cause = 0; m_irq = 0;
            for (int i = 0; i < 3; i++) src_hist[i] = 4'h0;
        end else begin
            // A source high two edges ago but low three edges ago pends now.
            rise = src_hist[1] & ~src_hist[2];
            src_hist[2] = src_hist[1];
            src_hist[1] = src_hist[0];
            src_hist[0] = irq_src;
            enabled = m_pending & m_mask;
            m_irq = 1'b0;
            if (cfg_we && cfg_addr == ADDR_CAUSE && cfg_wdata[7]) m_cause[7] = 1'b0;
            case (m_mode)
                M_IDLE: if (!pc31 && (exception || enabled != 4'h0)) begin
                    m_epc  = pc;
                    m_mode = M_TRAP;
                    if (exception) m_cause = {m_cause[7], 7'h10};
                    else begin
                        m_cause = {m_cause[7], 3'b000, winner(enabled)};
                        m_irq   = 1'b1;
                    end
                end
                M_TRAP: begin
                    if (exception) m_cause[7] = 1'b1;
                    m_mode = M_KERNEL;
                end
                default: begin
                    if (exception) m_cause[7] = 1'b1;
                    if (!pc31) m_mode = M_IDLE;
                end
            endcase
            clr = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[3:0] : 4'h0;
            m_pending = (m_pending & ~clr) | rise;
            if (cfg_we && cfg_addr == ADDR_MASK) m_mask = cfg_wdata[3:0];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_irq",   32'(irq),   32'(m_irq));
            check("cyc_epc",   epc,        m_epc);
            check("cyc_cause", 32'(cause), 32'(m_cause));
            check("cyc_rdata", cfg_rdata,  model_rdata(cfg_addr));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        cfg_addr = a;
        #1;
        check(name, cfg_rdata, exp);
    endtask

    task automatic wait_irq(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (irq === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: irq stayed 0 for %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic pulse_src(input logic [3:0] v);
        irq_src = v;
        step(2);
        irq_src = 4'h0;
    endtask

    initial begin
        // Reset must override a simultaneous write and trap condition.
        reset = 1'b1; irq_src = 4'h0; pc = 32'h0040_0000; pc31 = 1'b0; exception = 1'b1;
        cfg_we = 1'b1; cfg_addr = ADDR_MASK; cfg_wdata = 32'hF;
        step(2);
        cfg_we = 1'b0; cfg_wdata = '0; exception = 1'b0; reset = 1'b0;
        cmp_en = 1'b1;
        check("rst_irq",   32'(irq),   32'h0);
        check("rst_epc",   epc,        32'h0);
        check("rst_cause", 32'(cause), 32'h0);
        read_check(ADDR_MASK,    32'h0, "rst_mask");
        read_check(ADDR_PENDING, 32'h0, "rst_pending");

        // Single enabled interrupt.
        cfg_write(ADDR_MASK, 32'h1);
        pc = 32'h0040_0010;
        pulse_src(4'b0001);
        wait_irq("t1_irq", 10);
        check("t1_epc",   epc,        32'h0040_0010);
        check("t1_cause", 32'(cause), 32'h01);
        step();
        check("t1_irq_once", 32'(irq), 32'h0);
        pc31 = 1'b1; pc = 32'h8000_0180;
        read_check(ADDR_PENDING, 32'h1, "t1_pending");
        cfg_write(ADDR_PENDING, 32'h1);
        read_check(ADDR_PENDING, 32'h0, "t1_pending_clr");
        pc31 = 1'b0; pc = 32'h0040_0014;
        step(2);

        // Two simultaneous sources: priority, then the second after clearing.
        cfg_write(ADDR_MASK, 32'hF);
        pulse_src(4'b0110);
        wait_irq("t2_irq_a", 10);
        check("t2_cause_a", 32'(cause), 32'h02);
        check("t2_epc_a",   epc,        32'h0040_0014);
        step();
        pc31 = 1'b1; pc = 32'h8000_0180;
        read_check(ADDR_PENDING, 32'h6, "t2_pending_a");
        cfg_write(ADDR_PENDING, 32'h2);
        read_check(ADDR_PENDING, 32'h4, "t2_pending_b");
        pc31 = 1'b0; pc = 32'h0040_0018;
        wait_irq("t2_irq_b", 10);
        check("t2_cause_b", 32'(cause), 32'h04);
        check("t2_epc_b",   epc,        32'h0040_0018);
        step();
        pc31 = 1'b1; pc = 32'h8000_0180;
        cfg_write(ADDR_PENDING, 32'h4);
        read_check(ADDR_PENDING, 32'h0, "t2_pending_clr");

        // Exception beats an enabled pending interrupt.
        pulse_src(4'b1000);
        step(4);
        read_check(ADDR_PENDING, 32'h8, "t3_pending_pre");
        pc = 32'h0040_0020; pc31 = 1'b0;
        step();
        exception = 1'b1;
        step();
        exception = 1'b0; pc31 = 1'b1; pc = 32'h8000_0180;
        check("t3_irq",   32'(irq),   32'h0);
        check("t3_cause", 32'(cause), 32'h10);
        check("t3_epc",   epc,        32'h0040_0020);
        read_check(ADDR_PENDING, 32'h8, "t3_pending_kept");

        // Double fault while in the handler; EPC writes ignored; W1C of cause[7].
        step();
        pc = 32'h8000_0184; exception = 1'b1;
        step();
        exception = 1'b0;
        check("t4_cause_df", 32'(cause), 32'h90);
        check("t4_epc_kept", epc,        32'h0040_0020);
        cfg_write(ADDR_EPC, 32'hDEAD_BEEF);
        check("t4_epc_ro", epc, 32'h0040_0020);
        cfg_write(ADDR_CAUSE, 32'h80);
        check("t4_cause_clr", 32'(cause), 32'h10);
        cfg_write(ADDR_PENDING, 32'h8);
        cfg_write(ADDR_MASK, 32'h0);
        pc31 = 1'b0; pc = 32'h0040_0030;
        step(2);

        // Masked source pends silently until the mask opens.
        pulse_src(4'b1000);
        step(4);
        read_check(ADDR_PENDING, 32'h8, "t5_pending");
        check("t5_no_irq", 32'(irq), 32'h0);
        cfg_write(ADDR_MASK, 32'h8);
        check("t5_irq_wait", 32'(irq), 32'h0);
        step();
        check("t5_irq",   32'(irq),   32'h1);
        check("t5_cause", 32'(cause), 32'h08);
        step();
        pc31 = 1'b1; pc = 32'h8000_0180;
        check("t5_irq_end", 32'(irq), 32'h0);

        // Reset during KERNEL with a pending interrupt.
        cfg_write(ADDR_PENDING, 32'h8);
        pulse_src(4'b0001);
        step(4);
        read_check(ADDR_PENDING, 32'h1, "t6_pending_pre");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_epc",   epc,        32'h0);
        check("t6_cause", 32'(cause), 32'h0);
        check("t6_irq",   32'(irq),   32'h0);
        read_check(ADDR_MASK,    32'h0, "t6_mask");
        read_check(ADDR_PENDING, 32'h0, "t6_pending");
        pc31 = 1'b0; pc = 32'h0040_0040;
        cfg_write(ADDR_MASK, 32'hF);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t6_quiet_irq", 32'(irq), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 irq_src  in  4  level-sensitive external interrupt lines, asynchronous to clk.
REQ-004 pc  in  32  PC of the instruction currently in decode.
REQ-005 pc31  in  1  pc[31]; 1 = kernel space (handler running).
REQ-006 exception  in  1  illegal-instruction flag from the control decoder, same cycle as pc.
REQ-007 irq  out  1  trap request to the control decoder; 1-cycle pulse.
REQ-008 epc  out  32  PC of the trapped instruction.
REQ-009 cause  out  8  [7] double-fault sticky, [4] exception, [3:0] one-hot irq source taken.
REQ-010 cfg_we  in  1  register write strobe.
REQ-011 cfg_addr  in  2  0 MASK, 1 PENDING, 2 EPC, 3 CAUSE.
REQ-012 cfg_wdata  in  32  write data; only [7:0] used.
REQ-013 cfg_rdata  out  32  combinational read of the addressed register, zero-extended.

Function
REQ-014 Each irq_src bit SHALL pass a 2-FF synchronizer; a synchronized 0->1 edge SHALL set PENDING[i] on the following clock (3 cycles after the source edge).
REQ-015 PENDING SHALL be write-1-to-clear via cfg addr 1; a simultaneous new edge and clear on the same bit SHALL leave the bit set.
REQ-016 MASK[3:0] SHALL be read/write; 1 = enabled; EPC and CAUSE writes SHALL be ignored, except that writing 1 to CAUSE[7] SHALL clear it.
REQ-017 States: IDLE, TRAP, KERNEL.
REQ-018 IDLE -> TRAP when pc31=0 and (PENDING & MASK) != 0, or when pc31=0 and exception=1.
REQ-019 In TRAP, irq SHALL be 1 only when the cause is an interrupt; it SHALL be 0 for an exception, which the decoder already traps; TRAP -> KERNEL unconditionally after 1 cycle.
REQ-020 On the IDLE->TRAP transition edge, epc SHALL capture pc and cause[4:0] SHALL be loaded.
REQ-021 Interrupt priority: lowest index wins; only the winning PENDING bit is recorded in cause[3:0]; PENDING bits are cleared only by software.
REQ-022 Exception and enabled pending interrupt in the same cycle: exception wins, cause=0x10, irq stays 0, PENDING unchanged.
REQ-023 KERNEL -> IDLE on the first cycle with pc31=0; re-entry into TRAP SHALL NOT occur before the following cycle.
REQ-024 exception=1 while in TRAP or KERNEL SHALL set cause[7] and SHALL NOT modify epc or cause[4:0].
REQ-025 irq SHALL never be 1 outside TRAP and never for 2 consecutive cycles.

Reset
REQ-026 On reset the block SHALL go to state IDLE with irq=0, epc=0, cause=0, MASK=0, PENDING=0 and synchronizers=0, overriding any simultaneous cfg write or trap condition.
REQ-027 Reset asserted in TRAP or KERNEL SHALL abort the trap; no irq pulse SHALL follow reset release until a new edge is pended.

Structure
REQ-028 The shared package irq_pkg SHALL hold the state enum, register address constants (ADDR_MASK..ADDR_CAUSE), cause bit positions and NUM_IRQ=4.
REQ-029 Sub-module irq_sync (parameterized 2-FF synchronizer plus rising-edge detect, width NUM_IRQ) SHALL be instantiated once.

Verification
REQ-030 MASK=0x1, pulse irq_src[0] at pc=0x00400010 -> irq high 1 cycle, epc=0x00400010, cause=0x01.
REQ-031 MASK=0xF, irq_src[2] and irq_src[1] rise together -> cause=0x02, PENDING=0x6; write PENDING=0x2, drop pc31 -> second trap with cause=0x04.
REQ-032 exception=1 with PENDING&MASK=0x8 at pc=0x00400020 -> irq=0, cause=0x10, epc=0x00400020, PENDING=0x8 retained.
REQ-033 exception=1 while pc31=1 -> cause=0x90, epc unchanged; write CAUSE=0x80 -> cause=0x10.
REQ-034 MASK=0x0, edge on irq_src[3] -> PENDING=0x8, no irq; write MASK=0x8 -> irq 1 cycle later.
REQ-035 Reset asserted during KERNEL with PENDING=0x1 -> all registers 0 next cycle, no irq for 20 cycles after release with irq_src idle.
